// File: rtl/cache_stats_reader.sv
// cache_stats_reader: sweeps statistics indices through the controller and streams the frozen snapshot out
module cache_stats_reader #(
  parameter int FIRST_INDEX   = 0,
  parameter int LAST_INDEX    = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        count_en_i,
  output logic [31:0] comm_o,
  output logic [1:0]  select_o,
  input  logic [31:0] comm_i,
  output logic [31:0] word_o,
  output logic [4:0]  index_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        done_o
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DRIVE   = 3'd1;
  localparam logic [2:0] SETTLE  = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  localparam logic [4:0] FIRST       = 5'(FIRST_INDEX);
  localparam logic [4:0] LAST        = 5'(LAST_INDEX);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  logic [2:0] state, state_n;
  logic [4:0] index, index_n;
  logic [3:0] settle_cnt;
  always_comb begin
    state_n = state;
    index_n = index;
    case (state)
      IDLE: if (start_i) begin
        state_n = DRIVE;
        index_n = FIRST;
      end
      DRIVE:   state_n = SETTLE;
      SETTLE:  state_n = (settle_cnt == 4'd0) ? CAPTURE : SETTLE;
      CAPTURE: state_n = SEND;
      SEND: if (ready_i) begin
        state_n = (index == LAST) ? DONE : DRIVE;
        index_n = (index == LAST) ? index : index + 5'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state      <= IDLE;
      index      <= FIRST;
      settle_cnt <= 4'd0;
      word_o     <= 32'd0;
      index_o    <= 5'd0;
      comm_o     <= 32'd0;
    end else begin
      state      <= state_n;
      index      <= index_n;
      settle_cnt <= (state == DRIVE) ? SETTLE_LOAD :
                    (state == SETTLE && settle_cnt != 4'd0) ? settle_cnt - 4'd1 : settle_cnt;
      comm_o     <= {7'd0, count_en_i & (state_n == IDLE), 19'd0, index_n};
      if (state == CAPTURE) begin
        word_o  <= comm_i;
        index_o <= index;
      end
    end
  end
  assign select_o = 2'b00;
  assign valid_o  = (state == SEND);
  assign done_o   = (state == DONE);
  assign busy_o   = (state != IDLE);
endmodule

// File: tb/tb_cache_stats_reader.sv
// tb_cache_stats_reader: directed self-checking bench for cache_stats_reader
module tb_cache_stats_reader;
  logic clk;
  logic reset_i, start_i, count_en_i, ready_i;
  logic [31:0] comm_o, comm_i, word_o;
  logic [1:0] select_o;
  logic [4:0] index_o;
  logic valid_o, busy_o, done_o;
  logic start2, ready2;
  logic [31:0] comm2_o, comm2_i, word2;
  logic [1:0] select2;
  logic [4:0] index2;
  logic valid2, busy2, done2;
  logic [31:0] cnt;
  int tests, fails;
  typedef struct {
    int stall_idx;
    int stall_len;
    int restart_idx;
    int exp_cycles;
  } vec_t;
  vec_t vecs[5];
  cache_stats_reader dut (
    .clock_i(clk), .reset_i(reset_i), .start_i(start_i), .count_en_i(count_en_i),
    .comm_o(comm_o), .select_o(select_o), .comm_i(comm_i), .word_o(word_o),
    .index_o(index_o), .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o)
  );
  cache_stats_reader #(.FIRST_INDEX(15), .LAST_INDEX(15), .SETTLE_CYCLES(1)) dut2 (
    .clock_i(clk), .reset_i(reset_i), .start_i(start2), .count_en_i(1'b0),
    .comm_o(comm2_o), .select_o(select2), .comm_i(comm2_i), .word_o(word2),
    .index_o(index2), .valid_o(valid2), .ready_i(ready2), .busy_o(busy2), .done_o(done2)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    comm_i  <= 32'h1000 + {27'd0, comm_o[4:0]};
    comm2_i <= 32'h1000 + {27'd0, comm2_o[4:0]};
    if (reset_i) cnt <= 32'd0;
    else if (comm_o[24]) cnt <= cnt + 32'd1;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  task automatic run_sweep(input int row, input int si, input int sl, input int ri, input int ec);
    int n, st, frz, stl, c24, seq;
    bit got0, pulsed;
    logic [31:0] cnt0;
    logic [4:0] idxq[$];
    logic [31:0] wq[$];
    n = 0; st = 0; frz = 0; stl = 0; c24 = 0; seq = 0; got0 = 0; pulsed = 0; cnt0 = 0;
    @(negedge clk);
    start_i = 1'b1;
    ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    while (!done_o && n < 2000) begin
      start_i = !pulsed && valid_o && int'(index_o) == ri;
      if (start_i) pulsed = 1;
      ready_i = !(valid_o && int'(index_o) == si && st < sl);
      if (!ready_i) begin
        st++;
        if (word_o !== 32'h1000 + si) stl++;
      end
      if (comm_o[24]) c24++;
      if (valid_o && ready_i) begin
        idxq.push_back(index_o);
        wq.push_back(word_o);
        if (!got0) begin
          cnt0 = cnt;
          got0 = 1;
        end else if (cnt !== cnt0) frz++;
      end
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < idxq.size(); i++)
      if (int'(idxq[i]) != i || wq[i] !== 32'h1000 + i) seq++;
    chk($sformatf("row%0d cycles", row), n, ec);
    chk($sformatf("row%0d transfers", row), idxq.size(), 17);
    chk($sformatf("row%0d order", row), seq, 0);
    chk($sformatf("row%0d snapshot", row), frz, 0);
    chk($sformatf("row%0d stall_word", row), stl, 0);
    chk($sformatf("row%0d stall_len", row), st, sl);
    chk($sformatf("row%0d count_en_sweep", row), c24, 0);
    chk($sformatf("row%0d count_en_done", row), comm_o[24], 0);
    @(negedge clk);
    chk($sformatf("row%0d done_once", row), done_o, 0);
    chk($sformatf("row%0d busy_fall", row), busy_o, 0);
    chk($sformatf("row%0d count_en_after", row), comm_o[24], 1);
    chk($sformatf("row%0d frozen_end", row), cnt, cnt0);
  endtask
  initial begin
    int n, nd, nv;
    logic [31:0] w2;
    logic [4:0] i2;
    tests = 0; fails = 0;
    vecs[0] = '{-1, 0, -1, 85};
    vecs[1] = '{5, 10, -1, 95};
    vecs[2] = '{-1, 0, 3, 85};
    vecs[3] = '{16, 1, -1, 86};
    vecs[4] = '{0, 3, -1, 88};
    reset_i = 1'b1; start_i = 1'b0; count_en_i = 1'b1; ready_i = 1'b1;
    start2 = 1'b0; ready2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset valid", valid_o, 0);
    chk("reset done", done_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset word", word_o, 0);
    chk("reset index", index_o, 0);
    chk("reset comm", comm_o, 0);
    chk("reset select", select_o, 0);
    chk("reset select2", select2, 0);
    reset_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle count_en", comm_o[24], 1);
    count_en_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle count_dis", comm_o, 0);
    count_en_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int r = 0; r < 5; r++)
      run_sweep(r, vecs[r].stall_idx, vecs[r].stall_len, vecs[r].restart_idx, vecs[r].exp_cycles);
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (!(valid_o && index_o == 5'd8) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached index8", valid_o && index_o == 5'd8, 1);
    reset_i = 1'b1;
    @(negedge clk);
    chk("abort valid", valid_o, 0);
    chk("abort busy", busy_o, 0);
    chk("abort comm", comm_o, 0);
    chk("abort done", done_o, 0);
    reset_i = 1'b0;
    nd = 0;
    repeat (100) begin
      @(negedge clk);
      if (done_o) nd++;
    end
    chk("abort no_done", nd, 0);
    run_sweep(5, -1, 0, -1, 85);
    @(negedge clk);
    reset_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    start_i = 1'b0;
    chk("reset_prio busy", busy_o, 0);
    @(negedge clk);
    chk("reset_prio busy2", busy_o, 0);
    chk("reset_prio valid", valid_o, 0);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0; nv = 0; w2 = 0; i2 = 0;
    while (!done2 && n < 100) begin
      if (valid2) begin
        w2 = word2;
        i2 = index2;
        nv++;
      end
      @(negedge clk);
      n++;
    end
    chk("single cycles", n, 4);
    chk("single word", w2, 32'h100F);
    chk("single index", i2, 15);
    chk("single count", nv, 1);
    @(negedge clk);
    chk("single done_once", done2, 0);
    chk("single busy_fall", busy2, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
